// File: rtl/ilkn_frame_sync_control.sv
// Interlaken receive-lane frame sync controller: word-lock gating, sync-word hunt/verify, locked-state health.
// Optional macro ILKN_FRAME_SYNC_SCRAM_CHECK_EN enables scrambler-state mismatch checking while LOCKED.
module ilkn_frame_sync_control #(
   parameter int META_LEN  = 2048,
   parameter int SYNC_GOOD = 4,
   parameter int SYNC_BAD  = 4,
   parameter int SCRAM_BAD = 3
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       word_locked,
   input  logic       din_valid,
   input  logic       din_sync,
   input  logic       din_scram_match,
   output logic       scram_load,
   output logic       aligner_rst,
   output logic       frame_locked,
   output logic       sync_err,
   output logic       scram_err,
   output logic [7:0] lock_loss_cnt
);

   localparam int PW = $clog2(META_LEN);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HUNT   = 3'd1;
   localparam logic [2:0] ST_VERIFY = 3'd2;
   localparam logic [2:0] ST_LOCKED = 3'd3;
   localparam logic [2:0] ST_RESYNC = 3'd4;

   localparam logic [PW-1:0] POS_SYNC  = '0;
   localparam logic [PW-1:0] POS_SCRAM = PW'(1);
   localparam logic [PW-1:0] POS_LAST  = PW'(META_LEN - 1);

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] pos_q, pos_d, pos_inc;
   logic [3:0]    good_q, good_d;
   logic [3:0]    bad_sync_q, bad_sync_d;
   logic          sync_err_q, sync_err_d;
   logic          frame_locked_q, frame_locked_d;
   logic          aligner_rst_q, aligner_rst_d;
   logic [7:0]    lock_loss_q, lock_loss_d;
   logic          scram_fail;

   assign pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);

   // The seed word is loaded blindly while verifying; it is only checked once LOCKED.
   assign scram_load = (state_q == ST_VERIFY) && din_valid && (pos_q == POS_SCRAM);

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      good_d     = good_q;
      bad_sync_d = (state_q == ST_LOCKED) ? bad_sync_q : 4'd0;
      sync_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            pos_d  = '0;
            good_d = 4'd0;
            if (word_locked) state_d = ST_HUNT;
         end
         ST_HUNT: begin
            if (din_valid && din_sync) begin
               good_d  = 4'd1;
               pos_d   = POS_SCRAM;
               state_d = ST_VERIFY;
            end
         end
         ST_VERIFY: begin
            if (din_valid) begin
               pos_d = pos_inc;
               if (pos_q == POS_SYNC) begin
                  if (din_sync) begin
                     good_d = good_q + 4'd1;
                     if (good_d == 4'(SYNC_GOOD)) state_d = ST_LOCKED;
                  end else begin
                     good_d  = 4'd0;
                     pos_d   = '0;
                     state_d = ST_HUNT;
                  end
               end
            end
         end
         ST_LOCKED: begin
            if (din_valid) begin
               pos_d = pos_inc;
               if (pos_q == POS_SYNC) begin
                  if (din_sync) begin
                     bad_sync_d = 4'd0;
                  end else begin
                     bad_sync_d = bad_sync_q + 4'd1;
                     sync_err_d = 1'b1;
                     if (bad_sync_d == 4'(SYNC_BAD)) state_d = ST_RESYNC;
                  end
               end else if (scram_fail) begin
                  state_d = ST_RESYNC;
               end
            end
         end
         ST_RESYNC: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Losing word lock overrides everything; the aligner is already slipping, so no restart.
      if (state_q != ST_IDLE && !word_locked) begin
         state_d    = ST_IDLE;
         pos_d      = '0;
         good_d     = 4'd0;
         bad_sync_d = 4'd0;
         sync_err_d = 1'b0;
      end

      frame_locked_d = (state_d == ST_LOCKED);
      aligner_rst_d  = (state_d == ST_RESYNC);
      lock_loss_d    = lock_loss_q;
      if (state_q == ST_LOCKED && state_d != ST_LOCKED && lock_loss_q != 8'hFF)
         lock_loss_d = lock_loss_q + 8'd1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q        <= ST_IDLE;
         pos_q          <= '0;
         good_q         <= 4'd0;
         bad_sync_q     <= 4'd0;
         sync_err_q     <= 1'b0;
         frame_locked_q <= 1'b0;
         aligner_rst_q  <= 1'b0;
         lock_loss_q    <= 8'd0;
      end else begin
         state_q        <= state_d;
         pos_q          <= pos_d;
         good_q         <= good_d;
         bad_sync_q     <= bad_sync_d;
         sync_err_q     <= sync_err_d;
         frame_locked_q <= frame_locked_d;
         aligner_rst_q  <= aligner_rst_d;
         lock_loss_q    <= lock_loss_d;
      end
   end

`ifdef ILKN_FRAME_SYNC_SCRAM_CHECK_EN
   logic [3:0] bad_scram_q, bad_scram_d;
   logic       scram_err_q, scram_err_d;
   logic       scram_check;

   assign scram_check = (state_q == ST_LOCKED) && word_locked && din_valid && (pos_q == POS_SCRAM);
   assign scram_fail  = scram_check && !din_scram_match && ((bad_scram_q + 4'd1) == 4'(SCRAM_BAD));

   always_comb begin
      bad_scram_d = bad_scram_q;
      scram_err_d = 1'b0;
      if (state_q != ST_LOCKED || !word_locked) begin
         bad_scram_d = 4'd0;
      end else if (scram_check) begin
         if (din_scram_match) begin
            bad_scram_d = 4'd0;
         end else begin
            bad_scram_d = bad_scram_q + 4'd1;
            scram_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         bad_scram_q <= 4'd0;
         scram_err_q <= 1'b0;
      end else begin
         bad_scram_q <= bad_scram_d;
         scram_err_q <= scram_err_d;
      end
   end

   assign scram_err = scram_err_q;
`else
   logic scram_match_unused;
   assign scram_match_unused = din_scram_match;
   assign scram_fail         = 1'b0;
   assign scram_err          = 1'b0;
`endif

   assign sync_err      = sync_err_q;
   assign frame_locked  = frame_locked_q;
   assign aligner_rst   = aligner_rst_q;
   assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_ilkn_frame_sync_control.sv
// Directed bench for ilkn_frame_sync_control with META_LEN=64 and default thresholds.
module tb_ilkn_frame_sync_control;

   localparam int ML = 64;

   logic       clk;
   logic       arst_n;
   logic       word_locked;
   logic       din_valid;
   logic       din_sync;
   logic       din_scram_match;
   logic       scram_load;
   logic       aligner_rst;
   logic       frame_locked;
   logic       sync_err;
   logic       scram_err;
   logic [7:0] lock_loss_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Pulse tallies gathered per cycle by the driver.
   int   n_load, n_bad_load, n_sync_err, n_scram_err, n_arst;
   logic last_load;
   logic fl_at_sync, arst_at_sync;

   ilkn_frame_sync_control #(.META_LEN(ML)) dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .word_locked     (word_locked),
      .din_valid       (din_valid),
      .din_sync        (din_sync),
      .din_scram_match (din_scram_match),
      .scram_load      (scram_load),
      .aligner_rst     (aligner_rst),
      .frame_locked    (frame_locked),
      .sync_err        (sync_err),
      .scram_err       (scram_err),
      .lock_loss_cnt   (lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_counts();
      n_load = 0; n_bad_load = 0; n_sync_err = 0; n_scram_err = 0; n_arst = 0;
   endtask

   // Entered at posedge+1; returns at the following posedge+1.
   task automatic cycle(input logic v, input logic s, input logic m);
      din_valid = v; din_sync = s; din_scram_match = m;
      #1;
      last_load = scram_load;
      @(posedge clk);
      #1;
      if (last_load)   n_load++;
      if (sync_err)    n_sync_err++;
      if (scram_err)   n_scram_err++;
      if (aligner_rst) n_arst++;
   endtask

   task automatic do_reset();
      arst_n = 1'b0; word_locked = 1'b0;
      din_valid = 1'b0; din_sync = 1'b0; din_scram_match = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arst_n = 1'b1;
      clear_counts();
   endtask

   // One metaframe: sync at word 0, scrambler word at word 1; gaps add 10 invalid cycles carrying junk.
   task automatic send_mf(input logic sync_ok, input logic scram_ok, input logic gaps);
      for (int i = 0; i < ML; i++) begin
         if (gaps && i >= 5 && i < 15) cycle(1'b0, 1'b1, 1'b0);
         cycle(1'b1, (i == 0) ? sync_ok : 1'b0, (i == 1) ? scram_ok : 1'b0);
         if (last_load && i != 1) n_bad_load++;
         if (i == 0) begin
            fl_at_sync   = frame_locked;
            arst_at_sync = aligner_rst;
         end
      end
   endtask

   task automatic bring_up(input logic gaps);
      word_locked = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      repeat (4) send_mf(1'b1, 1'b1, gaps);
   endtask

   task automatic test_reset();
      arst_n = 1'b0; word_locked = 1'b1;
      din_valid = 1'b1; din_sync = 1'b1; din_scram_match = 1'b1;
      #3;
      n_checks++;
      if ({scram_load, aligner_rst, frame_locked, sync_err, scram_err} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {scram_load, aligner_rst, frame_locked, sync_err, scram_err});
      end
      n_checks++;
      if (lock_loss_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_lock_loss: got %0d expected 0", lock_loss_cnt);
      end
      do_reset();
   endtask

   task automatic test_clean_bringup();
      do_reset();
      word_locked = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      repeat (3) send_mf(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (frame_locked !== 1'b0) begin
         n_errors++;
         $display("FAIL clean_early_lock: got %b expected 0", frame_locked);
      end
      send_mf(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (fl_at_sync !== 1'b1) begin
         n_errors++;
         $display("FAIL clean_lock_timing: got %b expected 1", fl_at_sync);
      end
      n_checks++;
      if (n_load !== 3) begin
         n_errors++;
         $display("FAIL clean_scram_load_count: got %0d expected 3", n_load);
      end
      n_checks++;
      if (n_bad_load !== 0) begin
         n_errors++;
         $display("FAIL clean_scram_load_pos: got %0d expected 0", n_bad_load);
      end
   endtask

   task automatic test_verify_fail();
      do_reset();
      word_locked = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      repeat (2) send_mf(1'b1, 1'b1, 1'b0);
      send_mf(1'b0, 1'b1, 1'b0);
      repeat (3) send_mf(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (frame_locked !== 1'b0) begin
         n_errors++;
         $display("FAIL verify_fail_no_lock: got %b expected 0", frame_locked);
      end
      send_mf(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (fl_at_sync !== 1'b1) begin
         n_errors++;
         $display("FAIL verify_fail_relock: got %b expected 1", fl_at_sync);
      end
      n_checks++;
      if (n_sync_err !== 0 || n_load !== 5) begin
         n_errors++;
         $display("FAIL verify_fail_pulses: got sync_err=%0d load=%0d expected 0 and 5", n_sync_err, n_load);
      end
   endtask

   task automatic test_sync_loss();
      do_reset();
      bring_up(1'b0);
      clear_counts();
      repeat (3) send_mf(1'b0, 1'b1, 1'b0);
      send_mf(1'b1, 1'b1, 1'b0);
      repeat (3) send_mf(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (frame_locked !== 1'b1 || n_arst !== 0 || n_sync_err !== 6) begin
         n_errors++;
         $display("FAIL sync_recover_held: got fl=%b arst=%0d err=%0d expected 1 0 6",
                  frame_locked, n_arst, n_sync_err);
      end
      send_mf(1'b1, 1'b1, 1'b0);
      clear_counts();
      repeat (4) send_mf(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (arst_at_sync !== 1'b1) begin
         n_errors++;
         $display("FAIL sync_loss_arst_timing: got %b expected 1", arst_at_sync);
      end
      n_checks++;
      if (n_sync_err !== 4 || n_arst !== 1) begin
         n_errors++;
         $display("FAIL sync_loss_pulses: got err=%0d arst=%0d expected 4 1", n_sync_err, n_arst);
      end
      n_checks++;
      if (frame_locked !== 1'b0 || lock_loss_cnt !== 8'd1) begin
         n_errors++;
         $display("FAIL sync_loss_state: got fl=%b cnt=%0d expected 0 1", frame_locked, lock_loss_cnt);
      end
   endtask

   task automatic test_scram_loss();
      do_reset();
      bring_up(1'b0);
      clear_counts();
      repeat (3) send_mf(1'b1, 1'b0, 1'b0);
`ifdef ILKN_FRAME_SYNC_SCRAM_CHECK_EN
      n_checks++;
      if (n_scram_err !== 3 || n_arst !== 1) begin
         n_errors++;
         $display("FAIL scram_loss_pulses: got err=%0d arst=%0d expected 3 1", n_scram_err, n_arst);
      end
      n_checks++;
      if (frame_locked !== 1'b0 || lock_loss_cnt !== 8'd1) begin
         n_errors++;
         $display("FAIL scram_loss_state: got fl=%b cnt=%0d expected 0 1", frame_locked, lock_loss_cnt);
      end
`else
      n_checks++;
      if (n_scram_err !== 0 || n_arst !== 0) begin
         n_errors++;
         $display("FAIL scram_ignored_pulses: got err=%0d arst=%0d expected 0 0", n_scram_err, n_arst);
      end
      n_checks++;
      if (frame_locked !== 1'b1 || lock_loss_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL scram_ignored_state: got fl=%b cnt=%0d expected 1 0", frame_locked, lock_loss_cnt);
      end
`endif
   endtask

   task automatic test_word_lock_drop();
      do_reset();
      bring_up(1'b0);
      repeat (3) send_mf(1'b0, 1'b1, 1'b0);
      clear_counts();
      word_locked = 1'b0;
      cycle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (frame_locked !== 1'b0 || aligner_rst !== 1'b0 || lock_loss_cnt !== 8'd1) begin
         n_errors++;
         $display("FAIL wl_drop_edge: got fl=%b arst=%b cnt=%0d expected 0 0 1",
                  frame_locked, aligner_rst, lock_loss_cnt);
      end
      repeat (3) cycle(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (n_arst !== 0 || lock_loss_cnt !== 8'd1 || n_load !== 0) begin
         n_errors++;
         $display("FAIL wl_drop_after: got arst=%0d cnt=%0d load=%0d expected 0 1 0",
                  n_arst, lock_loss_cnt, n_load);
      end
   endtask

   task automatic test_valid_gaps();
      do_reset();
      word_locked = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      repeat (3) send_mf(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (frame_locked !== 1'b0) begin
         n_errors++;
         $display("FAIL gaps_early_lock: got %b expected 0", frame_locked);
      end
      send_mf(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (fl_at_sync !== 1'b1 || n_load !== 3 || n_bad_load !== 0) begin
         n_errors++;
         $display("FAIL gaps_lock: got fl=%b load=%0d bad=%0d expected 1 3 0", fl_at_sync, n_load, n_bad_load);
      end
      clear_counts();
      repeat (2) send_mf(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (frame_locked !== 1'b1 || n_sync_err !== 0) begin
         n_errors++;
         $display("FAIL gaps_pos_tracking: got fl=%b err=%0d expected 1 0", frame_locked, n_sync_err);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      bring_up(1'b0);
      for (int k = 1; k <= 257; k++) begin
         word_locked = 1'b0;
         cycle(1'b0, 1'b0, 1'b0);
         if (k == 255) begin
            n_checks++;
            if (lock_loss_cnt !== 8'd255) begin
               n_errors++;
               $display("FAIL sat_255: got %0d expected 255", lock_loss_cnt);
            end
         end
         bring_up(1'b0);
      end
      n_checks++;
      if (lock_loss_cnt !== 8'd255 || frame_locked !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_hold: got cnt=%0d fl=%b expected 255 1", lock_loss_cnt, frame_locked);
      end
   endtask

   task automatic test_async_reset();
      #2;
      arst_n = 1'b0;
      #1;
      n_checks++;
      if ({scram_load, aligner_rst, frame_locked, sync_err, scram_err} !== 5'b0 || lock_loss_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL async_reset: got outs=%b cnt=%0d expected 00000 0",
                  {scram_load, aligner_rst, frame_locked, sync_err, scram_err}, lock_loss_cnt);
      end
      do_reset();
   endtask

   initial begin
      arst_n = 1'b0; word_locked = 1'b0;
      din_valid = 1'b0; din_sync = 1'b0; din_scram_match = 1'b0;
      clear_counts();
      last_load = 1'b0; fl_at_sync = 1'b0; arst_at_sync = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_clean_bringup();
      test_verify_fail();
      test_sync_loss();
      test_scram_loss();
      test_word_lock_drop();
      test_valid_gaps();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
